// File: rtl/mmc_spi_block_rx_if.sv
// Handshake bundle for mmc_spi_block_rx: start/status, SPI byte engine and block-buffer write port.
// The slave modport is the receiver's view; master is the surrounding logic's view.
interface mmc_spi_block_rx_if;
    logic        iSTART;
    logic        oBUSY;
    logic        oDONE;
    logic [1:0]  oERROR;
    logic        oSPI_REQ;
    logic [7:0]  oSPI_DATA;
    logic        iSPI_BUSY;
    logic        iSPI_VALID;
    logic [7:0]  iSPI_DATA;
    logic        oWR_REQ;
    logic [3:0]  oWR_MASK;
    logic [6:0]  oWR_ADDR;
    logic [31:0] oWR_DATA;

    modport slave (
        input  iSTART, iSPI_BUSY, iSPI_VALID, iSPI_DATA,
        output oBUSY, oDONE, oERROR, oSPI_REQ, oSPI_DATA,
        output oWR_REQ, oWR_MASK, oWR_ADDR, oWR_DATA
    );

    modport master (
        output iSTART, iSPI_BUSY, iSPI_VALID, iSPI_DATA,
        input  oBUSY, oDONE, oERROR, oSPI_REQ, oSPI_DATA,
        input  oWR_REQ, oWR_MASK, oWR_ADDR, oWR_DATA
    );
endinterface

// File: rtl/mmc_spi_block_rx.sv
// Receives one 512-byte MMC/SD SPI-mode data block into a 128x32 byte-masked buffer.
// Optional CRC16-CCITT check of the block: define MMC_SPI_BLOCK_RX_CRC_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for iSTART
// TOKEN   | polling 0xFF bytes until the 0xFE start token
// DATA    | 512 data bytes, one single-lane buffer write per byte
// CRC     | CRC hi then lo byte
// DONE    | one-cycle oDONE, result held in oERROR
module mmc_spi_block_rx #(
    parameter logic [15:0] P_TOKEN_TIMEOUT = 16'd4096
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    mmc_spi_block_rx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TOKEN = 3'd1,
        S_DATA  = 3'd2,
        S_CRC   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_pending;
    logic [15:0] r_poll_cnt;
    logic [8:0]  r_byte_cnt;
    logic        r_crc_sel;
    logic        r_busy;
    logic        r_done;
    logic [1:0]  r_error;
    logic        r_spi_req;
    logic        r_wr_req;
    logic [3:0]  r_wr_mask;
    logic [6:0]  r_wr_addr;
    logic [31:0] r_wr_data;
`ifdef MMC_SPI_BLOCK_RX_CRC_CHECK_EN
    logic [15:0] r_crc;
    logic [7:0]  r_crc_hi;

    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    logic       w_need_byte;
    logic       w_issue;
    logic       w_rx;
    logic [3:0] w_lane_mask;

    assign w_need_byte = (r_state == S_TOKEN) || (r_state == S_DATA) || (r_state == S_CRC);
    assign w_issue     = w_need_byte && !bus.iSPI_BUSY && !r_pending;
    // A valid strobe only counts when we actually asked for a byte.
    assign w_rx        = bus.iSPI_VALID && r_pending;

    // Big-endian lanes: byte 0 of a word lands in [31:24].
    always_comb begin
        w_lane_mask = 4'hF;
        case (r_byte_cnt[1:0])
            2'd0: w_lane_mask = 4'b0111;
            2'd1: w_lane_mask = 4'b1011;
            2'd2: w_lane_mask = 4'b1101;
            2'd3: w_lane_mask = 4'b1110;
            default: w_lane_mask = 4'hF;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state    <= S_IDLE;
            r_pending  <= 1'b0;
            r_poll_cnt <= 16'd0;
            r_byte_cnt <= 9'd0;
            r_crc_sel  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 2'b00;
            r_spi_req  <= 1'b0;
            r_wr_req   <= 1'b0;
            r_wr_mask  <= 4'hF;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 32'd0;
`ifdef MMC_SPI_BLOCK_RX_CRC_CHECK_EN
            r_crc      <= 16'd0;
            r_crc_hi   <= 8'd0;
`endif
        end else begin
            r_spi_req <= 1'b0;
            r_done    <= 1'b0;
            r_wr_req  <= 1'b0;
            r_wr_mask <= 4'hF;

            if (w_issue) begin
                r_spi_req <= 1'b1;
                r_pending <= 1'b1;
            end else if (w_rx) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.iSTART) begin
                        r_state    <= S_TOKEN;
                        r_busy     <= 1'b1;
                        r_poll_cnt <= 16'd0;
                        r_byte_cnt <= 9'd0;
                        r_crc_sel  <= 1'b0;
                        r_error    <= 2'b00;
`ifdef MMC_SPI_BLOCK_RX_CRC_CHECK_EN
                        r_crc      <= 16'd0;
`endif
                    end
                end
                S_TOKEN: begin
                    if (w_rx) begin
                        if (bus.iSPI_DATA == 8'hFF) begin
                            r_poll_cnt <= r_poll_cnt + 16'd1;
                            if (r_poll_cnt + 16'd1 == P_TOKEN_TIMEOUT) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_error <= 2'b01;
                            end
                        end else if (bus.iSPI_DATA == 8'hFE) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_error <= 2'b10;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx) begin
                        r_wr_req   <= 1'b1;
                        r_wr_addr  <= r_byte_cnt[8:2];
                        r_wr_mask  <= w_lane_mask;
                        r_wr_data  <= {4{bus.iSPI_DATA}};
`ifdef MMC_SPI_BLOCK_RX_CRC_CHECK_EN
                        r_crc      <= f_crc16_byte(r_crc, bus.iSPI_DATA);
`endif
                        r_byte_cnt <= r_byte_cnt + 9'd1;
                        if (r_byte_cnt == 9'd511) r_state <= S_CRC;
                    end
                end
                S_CRC: begin
                    if (w_rx) begin
                        if (!r_crc_sel) begin
                            r_crc_sel <= 1'b1;
`ifdef MMC_SPI_BLOCK_RX_CRC_CHECK_EN
                            r_crc_hi  <= bus.iSPI_DATA;
`endif
                        end else begin
                            r_crc_sel <= 1'b0;
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
`ifdef MMC_SPI_BLOCK_RX_CRC_CHECK_EN
                            r_error   <= (r_crc != {r_crc_hi, bus.iSPI_DATA}) ? 2'b11 : 2'b00;
`else
                            r_error   <= 2'b00;
`endif
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oBUSY     = r_busy;
    assign bus.oDONE     = r_done;
    assign bus.oERROR    = r_error;
    assign bus.oSPI_REQ  = r_spi_req;
    assign bus.oSPI_DATA = 8'hFF;
    assign bus.oWR_REQ   = r_wr_req;
    assign bus.oWR_MASK  = r_wr_mask;
    assign bus.oWR_ADDR  = r_wr_addr;
    assign bus.oWR_DATA  = r_wr_data;

endmodule

// File: tb/tb_mmc_spi_block_rx.sv
// Bench for mmc_spi_block_rx: byte-stream model predicts writes and result code, checked every cycle.
// Expectations for the CRC-mismatch case follow MMC_SPI_BLOCK_RX_CRC_CHECK_EN.
module tb_mmc_spi_block_rx;
    localparam logic [15:0] TO = 16'd16;
`ifdef MMC_SPI_BLOCK_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef struct {
        logic [6:0]  addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmc_spi_block_rx_if bus();

    mmc_spi_block_rx #(.P_TOKEN_TIMEOUT(TO)) dut (
        .iCLOCK (clk),
        .inRESET(rst_n),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  stim[$];
    logic [7:0]  spi_q[$];
    wr_t         exp_wr[$];
    logic [31:0] mem[128];
    logic [1:0]  exp_err = 2'b00;
    logic [1:0]  held_err = 2'b00;
    int          exp_nwr = 0;
    int          blk_nwr = 0;
    bit          in_block = 1'b0;
    bit          done_seen = 1'b0;
    bit          tb_pending = 1'b0;
    logic        busy_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Walk the byte stream by the protocol rules to predict result and buffer writes.
    task automatic plan();
        int          i;
        int          polls;
        logic [7:0]  b;
        logic [15:0] crc;
        logic [15:0] rx;
        logic [8:0]  n9;
        wr_t         w;
        i = 0;
        polls = 0;
        exp_wr.delete();
        exp_err = 2'b00;
        while (i < stim.size()) begin
            b = stim[i];
            i++;
            if (b == 8'hFF) begin
                polls++;
                if (polls == int'(TO)) begin
                    exp_err = 2'b01;
                    break;
                end
            end else if (b == 8'hFE) begin
                crc = 16'h0000;
                for (int n = 0; n < 512; n++) begin
                    n9 = 9'(n);
                    w.addr = n9[8:2];
                    w.mask = ~(4'b1000 >> n9[1:0]);
                    w.data = {4{stim[i + n]}};
                    exp_wr.push_back(w);
                    crc = crc16(crc, stim[i + n]);
                end
                rx = {stim[i + 512], stim[i + 513]};
                exp_err = (CRC_EN && crc != rx) ? 2'b11 : 2'b00;
                break;
            end else begin
                exp_err = 2'b10;
                break;
            end
        end
        exp_nwr = exp_wr.size();
        spi_q = stim;
    endtask

    task automatic build_block(input int n_ff, input int kind, input logic [15:0] crc_over);
        logic [15:0] crc;
        logic [7:0]  d;
        stim.delete();
        for (int k = 0; k < n_ff; k++) stim.push_back(8'hFF);
        stim.push_back(8'hFE);
        crc = 16'h0000;
        for (int n = 0; n < 512; n++) begin
            case (kind)
                0: d = 8'(n);
                1: d = 8'h00;
                default: d = 8'(n * 7 + 3);
            endcase
            stim.push_back(d);
            crc = crc16(crc, d);
        end
        if (kind == 1) crc = crc_over;
        stim.push_back(crc[15:8]);
        stim.push_back(crc[7:0]);
    endtask

    task automatic start_blk();
        @(negedge clk); #1;
        bus.iSTART = 1'b1;
        in_block = 1'b1;
        blk_nwr = 0;
        done_seen = 1'b0;
        @(negedge clk); #1;
        bus.iSTART = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (done_seen) return;
        end
        chk("done_timeout", 32'(done_seen), 32'd1);
        in_block = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     32'(bus.oBUSY),     32'd0);
        chk({tag, "_done"},     32'(bus.oDONE),     32'd0);
        chk({tag, "_error"},    32'(bus.oERROR),    32'd0);
        chk({tag, "_spi_req"},  32'(bus.oSPI_REQ),  32'd0);
        chk({tag, "_spi_data"}, 32'(bus.oSPI_DATA), 32'hFF);
        chk({tag, "_wr_req"},   32'(bus.oWR_REQ),   32'd0);
        chk({tag, "_wr_mask"},  32'(bus.oWR_MASK),  32'hF);
    endtask

    always @(posedge clk) busy_q <= bus.iSPI_BUSY;

    // SPI byte engine: answers each request one cycle later with the next queued byte.
    initial begin
        bus.iSPI_VALID = 1'b0;
        bus.iSPI_DATA  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && bus.oSPI_REQ) begin
                @(negedge clk); #1;
                bus.iSPI_VALID = 1'b1;
                bus.iSPI_DATA  = (spi_q.size() > 0) ? spi_q.pop_front() : 8'hFF;
                @(negedge clk); #1;
                bus.iSPI_VALID = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            tb_pending = 1'b0;
        end else begin
            if (bus.oSPI_REQ) begin
                chk("spi_req_while_busy", 32'(busy_q), 32'd0);
                chk("spi_one_outstanding", 32'(tb_pending), 32'd0);
                chk("spi_tx_byte", 32'(bus.oSPI_DATA), 32'hFF);
                tb_pending = 1'b1;
            end
            if (bus.iSPI_VALID) tb_pending = 1'b0;

            if (bus.oWR_REQ) begin
                chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(bus.oWR_ADDR), 32'(e.addr));
                    chk("wr_mask", 32'(bus.oWR_MASK), 32'(e.mask));
                    chk("wr_data", bus.oWR_DATA, e.data);
                end
                for (int k = 0; k < 4; k++)
                    if (!bus.oWR_MASK[k]) mem[bus.oWR_ADDR][8*k +: 8] = bus.oWR_DATA[8*k +: 8];
                blk_nwr++;
            end

            if (bus.oDONE) begin
                chk("busy_at_done", 32'(bus.oBUSY), 32'd0);
                chk("done_in_block", 32'(in_block), 32'd1);
                chk("error_code", 32'(bus.oERROR), 32'(exp_err));
                chk("write_count", 32'(blk_nwr), 32'(exp_nwr));
                held_err = exp_err;
                in_block = 1'b0;
                done_seen = 1'b1;
            end else begin
                chk("busy", 32'(bus.oBUSY), 32'(in_block));
                chk("error_hold", 32'(bus.oERROR), in_block ? 32'd0 : 32'(held_err));
            end
        end
    end

    initial begin
        logic [15:0] c;
        logic [7:0]  s9 [9];
        bus.iSTART = 1'b0;
        bus.iSPI_BUSY = 1'b0;
        for (int k = 0; k < 128; k++) mem[k] = 32'h0;

        // Pin the CRC model: CRC16/XMODEM("123456789") = 0x31C3.
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 16'h0000;
        for (int k = 0; k < 9; k++) c = crc16(c, s9[k]);
        chk("model_crc_check", 32'(c), 32'h31C3);

        #12;
        chk_reset_outputs("reset");
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Ramp block with three poll bytes.
        build_block(3, 0, 16'h0);
        plan();
        start_blk();
        wait_done(5000);
        // iSTART during the DONE cycle must be ignored.
        bus.iSTART = 1'b1;
        @(negedge clk); #1;
        bus.iSTART = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_writes", 32'(blk_nwr), 32'd512);
        chk("t1_word0", mem[0], 32'h00010203);
        chk("t1_word127", mem[127], 32'hFCFDFEFF);
        chk("t1_error", 32'(bus.oERROR), 32'd0);

        // Token timeout.
        stim.delete();
        for (int k = 0; k < 20; k++) stim.push_back(8'hFF);
        plan();
        start_blk();
        wait_done(500);
        chk("t2_error", 32'(bus.oERROR), 32'd1);
        chk("t2_writes", 32'(blk_nwr), 32'd0);
        repeat (4) @(negedge clk);

        // Error token.
        stim = '{8'hFF, 8'hFF, 8'h05, 8'hFE, 8'h11};
        plan();
        start_blk();
        wait_done(200);
        chk("t3_error", 32'(bus.oERROR), 32'd2);
        chk("t3_writes", 32'(blk_nwr), 32'd0);
        repeat (4) @(negedge clk);

        // Zero block with matching CRC.
        build_block(0, 1, 16'h0000);
        plan();
        start_blk();
        wait_done(5000);
        chk("t4a_error", 32'(bus.oERROR), 32'd0);
        repeat (4) @(negedge clk);

        // Zero block with wrong CRC.
        build_block(0, 1, 16'h1234);
        plan();
        start_blk();
        wait_done(5000);
        chk("t4b_error", 32'(bus.oERROR), CRC_EN ? 32'd3 : 32'd0);
        repeat (4) @(negedge clk);

        // Reset in the middle of the data phase.
        build_block(1, 0, 16'h0);
        plan();
        start_blk();
        for (int k = 0; k < 2000 && blk_nwr < 100; k++) begin
            @(negedge clk); #1;
        end
        chk("t5_reached_100", 32'(blk_nwr >= 100), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_abort");
        in_block = 1'b0;
        held_err = 2'b00;
        exp_wr.delete();
        repeat (5) @(negedge clk);
        spi_q.delete();
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 128; k++) mem[k] = 32'h0;
        build_block(2, 0, 16'h0);
        plan();
        start_blk();
        wait_done(5000);
        chk("t5_writes", 32'(blk_nwr), 32'd512);
        chk("t5_word0", mem[0], 32'h00010203);
        chk("t5_word127", mem[127], 32'hFCFDFEFF);
        repeat (4) @(negedge clk);

        // SPI engine busy stall plus a stray iSTART mid-block.
        build_block(1, 2, 16'h0);
        plan();
        start_blk();
        for (int k = 0; k < 2000 && blk_nwr < 50; k++) begin
            @(negedge clk); #1;
        end
        bus.iSPI_BUSY = 1'b1;
        bus.iSTART = 1'b1;
        @(negedge clk); #1;
        bus.iSTART = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        bus.iSPI_BUSY = 1'b0;
        wait_done(5000);
        chk("t6_writes", 32'(blk_nwr), 32'd512);
        chk("t6_word1", mem[1], 32'h1F262D34);
        chk("t6_error", 32'(bus.oERROR), 32'd0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
